// File: rtl/arithmetic_logic_seq_pkg.sv
// Operation and state encodings shared by the sequential ALU, its bus interface and the control unit.
package arithmetic_logic_seq_pkg;

  typedef enum logic [4:0] {
    amp  = 5'd0,
    lor  = 5'd1,
    flp  = 5'd2,
    eor  = 5'd3,
    rsc  = 5'd4,
    lsc  = 5'd5,
    add  = 5'd6,
    sub  = 5'd7,
    eql  = 5'd8,
    eqlk = 5'd9,
    revx = 5'd10,
    revy = 5'd11,
    parx = 5'd12,
    pary = 5'd13,
    rol  = 5'd14,
    ror  = 5'd15,
    mul  = 5'd16
  } math;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/arithmetic_logic_seq_if.sv
// Request/result bus between the control unit (master) and the sequential ALU (slave).
interface arithmetic_logic_seq_if #(parameter int W = 8);
  import arithmetic_logic_seq_pkg::*;

  logic [W-1:0] x;
  logic [W-1:0] y;
  math          math_op;
  logic         alu_rs;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] r_out;
  logic [W-1:0] s_out;
  logic         carry;
  logic         zero;
  logic         equal;
  logic         shift_out;

  modport master (
    output x, y, math_op, alu_rs, start,
    input  busy, done, r_out, s_out, carry, zero, equal, shift_out
  );

  modport slave (
    input  x, y, math_op, alu_rs, start,
    output busy, done, r_out, s_out, carry, zero, equal, shift_out
  );

endinterface

// File: rtl/arithmetic_logic_seq_add_sub_w.sv
// W-bit ripple adder shared by add, sub and the multiply accumulate; purely combinational.
// inv complements b, so inv=1 with cin=1 yields a-b and cout=1 means no borrow.
module arithmetic_logic_seq_add_sub_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic c;
  logic bi;

  always_comb begin
    c   = cin;
    bi  = 1'b0;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      bi     = b[i] ^ inv;
      sum[i] = a[i] ^ bi ^ c;
      c      = (a[i] & bi) | (c & (a[i] ^ bi));
    end
    cout = c;
  end

endmodule

// File: rtl/arithmetic_logic_seq.sv
// Sequential W-bit ALU: single-cycle ops finish in one step, rotates take `amount` steps, mul takes W.
// start is accepted only in IDLE and never queued; results and flags update on the edge entering DONE.
module arithmetic_logic_seq
  import arithmetic_logic_seq_pkg::*;
#(
  parameter int W    = 8,
  parameter int EQLK = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arithmetic_logic_seq_if.slave bus
);

  localparam int LW = $clog2(W);
  localparam int CW = LW + 1;

  alu_state_t     state;
  logic [CW-1:0]  cnt;
  math            op_q;
  logic           rs_q;
  logic           eq_q;
  logic [W-1:0]   xq;
  logic [2*W-1:0] prod;

  logic [W-1:0]   r_q, s_q;
  logic           carry_q, zero_q, equal_q, so_q;

  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_inv, add_cout;

  logic [W-1:0]   rev_x, rev_y;
  logic [W-1:0]   s_res;
  logic           s_c, s_so, s_ok;

  logic [CW-1:0]  amt;
  logic           last;
  logic [W-1:0]   rot_next;
  logic           rot_bit;
  logic [2*W-1:0] prod_next;

  assign bus.r_out     = r_q;
  assign bus.s_out     = s_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.equal     = equal_q;
  assign bus.shift_out = so_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

  // The adder serves raw operands in IDLE and the multiply accumulate in RUN.
  always_comb begin
    if (state == RUN) begin
      add_a   = prod[2*W-1:W];
      add_b   = prod[0] ? xq : '0;
      add_inv = 1'b0;
    end else begin
      add_a   = bus.x;
      add_b   = bus.y;
      add_inv = (bus.math_op == sub);
    end
  end

  arithmetic_logic_seq_add_sub_w #(.W(W)) u_add_sub (
    .a    (add_a),
    .b    (add_b),
    .inv  (add_inv),
    .cin  (add_inv),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    rev_x = '0;
    rev_y = '0;
    for (int i = 0; i < W; i++) begin
      rev_x[i] = bus.x[W-1-i];
      rev_y[i] = bus.y[W-1-i];
    end
  end

  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    s_so  = 1'b0;
    s_ok  = 1'b1;
    case (bus.math_op)
      amp:      s_res = bus.x & bus.y;
      lor:      s_res = bus.x | bus.y;
      flp:      s_res = ~bus.x;
      eor:      s_res = bus.x ^ bus.y;
      rsc: begin
        s_res = {bus.y[0], bus.x[W-1:1]};
        s_so  = bus.x[0];
      end
      lsc: begin
        s_res = {bus.x[W-2:0], bus.y[W-1]};
        s_so  = bus.x[W-1];
      end
      add, sub: begin
        s_res = add_sum;
        s_c   = add_cout;
      end
      eql:      s_res = {{(W-1){1'b0}}, (bus.x == bus.y)};
      eqlk:     s_res = {{(W-1){1'b0}}, (bus.x[EQLK-1:0] == bus.y[EQLK-1:0])};
      revx:     s_res = rev_x;
      revy:     s_res = rev_y;
      parx:     s_res = {{(W-1){1'b0}}, ^bus.x};
      pary:     s_res = {{(W-1){1'b0}}, ^bus.y};
      rol, ror: s_res = bus.x;  // reached only with a zero rotate amount
      mul:      s_res = '0;
      default:  s_ok  = 1'b0;
    endcase
  end

  assign amt       = {1'b0, bus.y[LW-1:0]};
  assign last      = (cnt == CW'(1));
  assign rot_next  = (op_q == rol) ? {xq[W-2:0], xq[W-1]} : {xq[0], xq[W-1:1]};
  assign rot_bit   = (op_q == rol) ? xq[W-1] : xq[0];
  assign prod_next = {add_cout, add_sum, prod[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= amp;
      rs_q    <= 1'b0;
      eq_q    <= 1'b0;
      xq      <= '0;
      prod    <= '0;
      r_q     <= '0;
      s_q     <= {{(W-1){1'b0}}, 1'b1};
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      equal_q <= 1'b0;
      so_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.math_op;
            rs_q <= bus.alu_rs;
            eq_q <= (bus.x == bus.y);
            xq   <= bus.x;
            prod <= {{W{1'b0}}, bus.y};
            if (bus.math_op == mul) begin
              cnt   <= CW'(W);
              state <= RUN;
            end else if ((bus.math_op == rol || bus.math_op == ror) && amt != '0) begin
              cnt   <= amt;
              state <= RUN;
            end else begin
              if (bus.alu_rs) s_q <= s_res;
              else            r_q <= s_res;
              carry_q <= s_c;
              zero_q  <= (s_res == '0);
              equal_q <= s_ok && (bus.x == bus.y);
              so_q    <= s_so;
              state   <= DONE;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (op_q == mul) begin
            prod <= prod_next;
            if (last) begin
              // Low half to the selected register, high half to the other one.
              if (rs_q) begin
                s_q <= prod_next[W-1:0];
                r_q <= prod_next[2*W-1:W];
              end else begin
                r_q <= prod_next[W-1:0];
                s_q <= prod_next[2*W-1:W];
              end
              carry_q <= |prod_next[2*W-1:W];
              zero_q  <= (prod_next[W-1:0] == '0);
              equal_q <= eq_q;
              so_q    <= 1'b0;
              state   <= DONE;
            end
          end else begin
            xq <= rot_next;
            if (last) begin
              if (rs_q) s_q <= rot_next;
              else      r_q <= rot_next;
              carry_q <= 1'b0;
              zero_q  <= (rot_next == '0);
              equal_q <= eq_q;
              so_q    <= rot_bit;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arithmetic_logic_seq.sv
// Directed self-checking bench for arithmetic_logic_seq at W=8 and W=16.
module tb_arithmetic_logic_seq;
  import arithmetic_logic_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  arithmetic_logic_seq_if #(.W(8))  bus8 ();
  arithmetic_logic_seq_if #(.W(16)) bus16 ();

  arithmetic_logic_seq #(.W(8), .EQLK(5)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  arithmetic_logic_seq #(.W(16), .EQLK(5)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op8(input math op, input logic [7:0] xv, input logic [7:0] yv,
                         input logic rs, output int cyc, output int nbusy);
    @(posedge clk); #1;
    bus8.math_op = op; bus8.x = xv; bus8.y = yv; bus8.alu_rs = rs; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc   = 1;
    nbusy = bus8.busy ? 1 : 0;
    while (!bus8.done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (bus8.busy) nbusy++;
    end
  endtask

  task automatic run_op16(input math op, input logic [15:0] xv, input logic [15:0] yv,
                          input logic rs, output int cyc);
    @(posedge clk); #1;
    bus16.math_op = op; bus16.x = xv; bus16.y = yv; bus16.alu_rs = rs; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    cyc = 1;
    while (!bus16.done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus8.r_out !== 8'h00) begin failures++; $display("FAIL reset_r got %h want 00", bus8.r_out); end
    checks++; if (bus8.s_out !== 8'h01) begin failures++; $display("FAIL reset_s got %h want 01", bus8.s_out); end
    checks++; if ({bus8.carry, bus8.zero, bus8.equal, bus8.shift_out} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got %b want 0000", {bus8.carry, bus8.zero, bus8.equal, bus8.shift_out}); end
    checks++; if ({bus8.busy, bus8.done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got %b want 00", {bus8.busy, bus8.done}); end
    checks++; if (bus16.s_out !== 16'h0001) begin failures++; $display("FAIL reset_s16 got %h want 0001", bus16.s_out); end
  endtask

  task automatic test_add;
    int cyc, nb;
    run_op8(add, 8'hF0, 8'h20, 1'b0, cyc, nb);
    checks++; if (cyc != 1) begin failures++; $display("FAIL add_latency got %0d want 1", cyc); end
    checks++; if (bus8.r_out !== 8'h10) begin failures++; $display("FAIL add_r got %h want 10", bus8.r_out); end
    checks++; if ({bus8.carry, bus8.zero} !== 2'b10) begin failures++; $display("FAIL add_flags got %b want 10", {bus8.carry, bus8.zero}); end
    checks++; if (bus8.s_out !== 8'h01) begin failures++; $display("FAIL add_s_hold got %h want 01", bus8.s_out); end
  endtask

  task automatic test_sub;
    int cyc, nb;
    run_op8(sub, 8'h05, 8'h05, 1'b0, cyc, nb);
    checks++; if (bus8.r_out !== 8'h00) begin failures++; $display("FAIL sub_eq_r got %h want 00", bus8.r_out); end
    checks++; if ({bus8.carry, bus8.zero, bus8.equal} !== 3'b111) begin
      failures++; $display("FAIL sub_eq_flags got %b want 111", {bus8.carry, bus8.zero, bus8.equal}); end
    run_op8(sub, 8'h03, 8'h05, 1'b0, cyc, nb);
    checks++; if (bus8.r_out !== 8'hFE) begin failures++; $display("FAIL sub_borrow_r got %h want FE", bus8.r_out); end
    checks++; if ({bus8.carry, bus8.zero, bus8.equal} !== 3'b000) begin
      failures++; $display("FAIL sub_borrow_flags got %b want 000", {bus8.carry, bus8.zero, bus8.equal}); end
  endtask

  task automatic test_rotate;
    int cyc, nb;
    run_op8(rol, 8'h81, 8'h03, 1'b1, cyc, nb);
    checks++; if (cyc != 4) begin failures++; $display("FAIL rol_latency got %0d want 4", cyc); end
    checks++; if (nb != 4) begin failures++; $display("FAIL rol_busy_cycles got %0d want 4", nb); end
    checks++; if (bus8.s_out !== 8'h0C) begin failures++; $display("FAIL rol_s got %h want 0C", bus8.s_out); end
    checks++; if (bus8.shift_out !== 1'b0) begin failures++; $display("FAIL rol_so got %b want 0", bus8.shift_out); end
    checks++; if (bus8.r_out !== 8'hFE) begin failures++; $display("FAIL rol_r_hold got %h want FE", bus8.r_out); end
    run_op8(ror, 8'h01, 8'h01, 1'b1, cyc, nb);
    checks++; if (cyc != 2) begin failures++; $display("FAIL ror_latency got %0d want 2", cyc); end
    checks++; if (bus8.s_out !== 8'h80) begin failures++; $display("FAIL ror_s got %h want 80", bus8.s_out); end
    checks++; if (bus8.shift_out !== 1'b1) begin failures++; $display("FAIL ror_so got %b want 1", bus8.shift_out); end
    run_op8(rol, 8'h5A, 8'h08, 1'b0, cyc, nb);
    checks++; if (cyc != 1) begin failures++; $display("FAIL rol0_latency got %0d want 1", cyc); end
    checks++; if ({bus8.r_out, bus8.shift_out} !== {8'h5A, 1'b0}) begin
      failures++; $display("FAIL rol0_result got %h/%b want 5A/0", bus8.r_out, bus8.shift_out); end
  endtask

  task automatic test_logic;
    math        ops [0:12] = '{amp, lor, flp, eor, rsc, lsc, revx, revy, parx, pary, eql, eqlk, math'(5'd20)};
    logic [7:0] xs  [0:12] = '{8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'h35, 8'hA7};
    logic [7:0] ys  [0:12] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h15, 8'h3C};
    logic [7:0] exp [0:12] = '{8'h24, 8'hBF, 8'h58, 8'h9B, 8'h53, 8'h4E, 8'hE5, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    logic       eso [0:12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ezr [0:12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int cyc, nb;
    for (int i = 0; i < 13; i++) begin
      run_op8(ops[i], xs[i], ys[i], 1'b0, cyc, nb);
      checks++; if (bus8.r_out !== exp[i]) begin
        failures++; $display("FAIL logic_r[%0d] got %h want %h", i, bus8.r_out, exp[i]); end
      checks++; if ({bus8.shift_out, bus8.zero, bus8.carry, bus8.equal} !== {eso[i], ezr[i], 2'b00}) begin
        failures++; $display("FAIL logic_flags[%0d] got %b want %b", i,
          {bus8.shift_out, bus8.zero, bus8.carry, bus8.equal}, {eso[i], ezr[i], 2'b00}); end
    end
  endtask

  task automatic test_mul;
    int cyc;
    @(posedge clk); #1;
    bus8.math_op = mul; bus8.x = 8'h12; bus8.y = 8'h34; bus8.alu_rs = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc = 1;
    while (!bus8.done && cyc < 50) begin
      if (cyc == 3) begin
        bus8.x = 8'hFF; bus8.math_op = add; bus8.start = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus8.start = 1'b0;
    checks++; if (cyc != 9) begin failures++; $display("FAIL mul_latency got %0d want 9", cyc); end
    checks++; if (bus8.r_out !== 8'hA8) begin failures++; $display("FAIL mul_lo got %h want A8", bus8.r_out); end
    checks++; if (bus8.s_out !== 8'h03) begin failures++; $display("FAIL mul_hi got %h want 03", bus8.s_out); end
    checks++; if ({bus8.carry, bus8.zero} !== 2'b10) begin failures++; $display("FAIL mul_flags got %b want 10", {bus8.carry, bus8.zero}); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus8.busy, bus8.done} !== 2'b00) begin failures++; $display("FAIL mul_no_queue got %b want 00", {bus8.busy, bus8.done}); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    ndone = 0;
    @(posedge clk); #1;
    bus8.math_op = add; bus8.x = 8'h01; bus8.y = 8'h01; bus8.alu_rs = 1'b0; bus8.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus8.done) ndone++;
    end
    bus8.start = 1'b0;
    checks++; if (ndone != 4) begin failures++; $display("FAIL b2b_done_count got %0d want 4", ndone); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, nb;
    @(posedge clk); #1;
    bus8.math_op = mul; bus8.x = 8'h12; bus8.y = 8'h34; bus8.alu_rs = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc = 1;
    while (cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus8.r_out, bus8.s_out} !== {8'h00, 8'h01}) begin
      failures++; $display("FAIL midrst_regs got %h/%h want 00/01", bus8.r_out, bus8.s_out); end
    checks++; if ({bus8.busy, bus8.done} !== 2'b00) begin failures++; $display("FAIL midrst_busy got %b want 00", {bus8.busy, bus8.done}); end
    #2 rst_n = 1'b1;
    run_op8(add, 8'h0F, 8'h01, 1'b0, cyc, nb);
    checks++; if (cyc != 1) begin failures++; $display("FAIL midrst_add_latency got %0d want 1", cyc); end
    checks++; if ({bus8.r_out, bus8.s_out} !== {8'h10, 8'h01}) begin
      failures++; $display("FAIL midrst_add got %h/%h want 10/01", bus8.r_out, bus8.s_out); end
  endtask

  task automatic test_w16;
    int cyc;
    run_op16(add, 16'hFFFF, 16'h0001, 1'b0, cyc);
    checks++; if (bus16.r_out !== 16'h0000) begin failures++; $display("FAIL w16_add_r got %h want 0000", bus16.r_out); end
    checks++; if ({bus16.carry, bus16.zero} !== 2'b11) begin failures++; $display("FAIL w16_add_flags got %b want 11", {bus16.carry, bus16.zero}); end
    run_op16(eqlk, 16'h1234, 16'h0054, 1'b1, cyc);
    checks++; if (bus16.s_out !== 16'h0001) begin failures++; $display("FAIL w16_eqlk got %h want 0001", bus16.s_out); end
    checks++; if ({bus16.zero, bus16.equal} !== 2'b00) begin failures++; $display("FAIL w16_eqlk_flags got %b want 00", {bus16.zero, bus16.equal}); end
    run_op16(sub, 16'h0000, 16'h0001, 1'b0, cyc);
    checks++; if ({bus16.r_out, bus16.carry} !== {16'hFFFF, 1'b0}) begin
      failures++; $display("FAIL w16_sub got %h/%b want FFFF/0", bus16.r_out, bus16.carry); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus8.x = '0;  bus8.y = '0;  bus8.math_op = amp;  bus8.alu_rs = 1'b0;  bus8.start = 1'b0;
    bus16.x = '0; bus16.y = '0; bus16.math_op = amp; bus16.alu_rs = 1'b0; bus16.start = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_rotate();
    test_logic();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
